funnel_shifter_seq: RTL

Parametrised, iterative funnel shifter with a valid/ready handshake. It is the multi-cycle successor of the 8-bit combinational shifter. It adds a configurable width, a configurable per-cycle shift step, two-operand funnel modes and a carry-out flag. It sits between operand registers and the writeback path and trades latency for a small STEP-wide shift stage.

---
 rtl/funnel_pkg.sv | 19 +
 rtl/funnel_step.sv | 64 ++++++
 rtl/funnel_shifter_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/funnel_pkg.sv
// Shared definitions for the iterative funnel shifter: mode encodings and FSM states.
package funnel_pkg;

    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASL = 3'b010;
    localparam logic [2:0] MODE_ASR = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;
    localparam logic [2:0] MODE_ROR = 3'b101;
    localparam logic [2:0] MODE_FSL = 3'b110;
    localparam logic [2:0] MODE_FSR = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/funnel_step.sv
// Single-stage combinational shift of the 2*WIDTH working word by 0..STEP positions.
// Ports:
//   word_i  working word (layout depends on mode, see funnel_shifter_seq)
//   mode_i  shift kind
//   amt_i   shift amount this stage, 0..STEP
//   word_o  shifted working word
//   bit_o   last bit that crossed the result boundary (0 when amt_i = 0 or funnel mode)
module funnel_step
    import funnel_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned STEP  = 1,
    localparam int unsigned AW    = $clog2(STEP) + 1
) (
    input  logic [2*WIDTH-1:0] word_i,
    input  logic [2:0]         mode_i,
    input  logic [AW-1:0]      amt_i,
    output logic [2*WIDTH-1:0] word_o,
    output logic               bit_o
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned IW = $clog2(DW);

    logic [IW-1:0] amt_w;
    logic [IW-1:0] amt_neg;

    // amt_neg = DW - amt (mod DW); a zero amount rotates by zero either way
    assign amt_w   = IW'(amt_i);
    assign amt_neg = IW'(0) - amt_w;

    always_comb begin
        word_o = word_i;
        bit_o  = 1'b0;
        case (mode_i)
            MODE_LSL, MODE_ASL: begin
                // value lives in the low half; bits leave it across position WIDTH-1
                word_o = word_i << amt_w;
                if (amt_w != '0) bit_o = word_i[IW'(WIDTH) - amt_w];
            end
            MODE_LSR: begin
                word_o = word_i >> amt_w;
                if (amt_w != '0) bit_o = word_i[IW'(WIDTH) + amt_w - IW'(1)];
            end
            MODE_ASR: begin
                word_o = $unsigned($signed(word_i) >>> amt_w);
                if (amt_w != '0) bit_o = word_i[IW'(WIDTH) + amt_w - IW'(1)];
            end
            MODE_ROL: begin
                // both halves hold the operand, so a DW-wide rotate is a WIDTH-wide rotate
                word_o = (word_i << amt_w) | (word_i >> amt_neg);
                if (amt_w != '0) bit_o = word_i[amt_neg];
            end
            MODE_ROR: begin
                word_o = (word_i >> amt_w) | (word_i << amt_neg);
                if (amt_w != '0) bit_o = word_i[amt_w - IW'(1)];
            end
            MODE_FSL: word_o = word_i << amt_w;
            MODE_FSR: word_o = word_i >> amt_w;
            default:  word_o = word_i;
        endcase
    end

endmodule

// File: rtl/funnel_shifter_seq.sv
// Iterative funnel shifter with valid/ready handshake; shifts up to STEP bits per cycle.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready depends combinationally on out_ready)
//   data_a, data_b        operands (data_b used only by funnel modes)
//   mode, s_count         shift kind and amount (0 .. 2*WIDTH-1)
//   out_valid / out_ready result handshake
//   result, carry_out     shifted value and last bit shifted out
module funnel_shifter_seq
    import funnel_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned STEP  = 1,
    localparam int unsigned CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [2:0]       mode,
    input  logic [CW-1:0]    s_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned AW = $clog2(STEP) + 1;
    localparam int unsigned LW = $clog2(WIDTH);

    state_e           state_q;
    logic [CW-1:0]    rem_q;
    logic [DW-1:0]    word_q;
    logic [2:0]       mode_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             out_valid_q;

    logic             accept;
    logic [CW-1:0]    c_eff;
    logic [DW-1:0]    init_word;
    logic [AW-1:0]    step_amt;
    logic [CW-1:0]    rem_next;
    logic [DW-1:0]    step_word;
    logic             step_bit;

    // Result half of the working word for each mode
    function automatic logic [WIDTH-1:0] pick_result(input logic [DW-1:0] w, input logic [2:0] m);
        if (m == MODE_LSL || m == MODE_ASL || m == MODE_FSR) return w[WIDTH-1:0];
        return w[DW-1:WIDTH];
    endfunction

    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry_out = carry_q;

    // Effective count: modulo WIDTH for rotates, saturated at WIDTH otherwise
    always_comb begin
        if (mode == MODE_ROL || mode == MODE_ROR)
            c_eff = CW'(s_count[LW-1:0]);
        else if (s_count >= CW'(WIDTH))
            c_eff = CW'(WIDTH);
        else
            c_eff = s_count;
    end

    // Working-word layout chosen so that shifting in from the far half yields the boundary results
    always_comb begin
        init_word = {data_a, data_b};
        case (mode)
            MODE_LSL, MODE_ASL: init_word = {{WIDTH{1'b0}}, data_a};
            MODE_LSR, MODE_ASR: init_word = {data_a, {WIDTH{1'b0}}};
            MODE_ROL, MODE_ROR: init_word = {data_a, data_a};
            default:            init_word = {data_a, data_b};
        endcase
    end

    assign step_amt = (rem_q >= CW'(STEP)) ? AW'(STEP) : AW'(rem_q);
    assign rem_next = rem_q - CW'(step_amt);

    funnel_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .word_i (word_q),
        .mode_i (mode_q),
        .amt_i  (step_amt),
        .word_o (step_word),
        .bit_o  (step_bit)
    );

    // Control FSM with registered result, carry and out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            word_q      <= '0;
            mode_q      <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        word_q  <= init_word;
                        mode_q  <= mode;
                        rem_q   <= c_eff;
                        carry_q <= 1'b0;
                        if (c_eff == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= pick_result(init_word, mode);
                        end else begin
                            state_q     <= SHIFT;
                            out_valid_q <= 1'b0;
                        end
                    end else if (state_q == DONE && out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    word_q  <= step_word;
                    rem_q   <= rem_next;
                    carry_q <= step_bit;
                    if (rem_next == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= pick_result(step_word, mode_q);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
